// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receiver: FSM encoding, legal oversampling
// ratios and parity-type encoding.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Anything outside the supported ratios falls back to 8.
    function automatic logic [7:0] legal_prescale(input logic [7:0] p);
        case (p)
            8'(PRESCALE_16): return 8'(PRESCALE_16);
            8'(PRESCALE_32): return 8'(PRESCALE_32);
            default:         return 8'(PRESCALE_8);
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Line synchronizer, per-bit edge counter and three-sample majority vote
// around the middle of each bit.
module uart_rx_bit_sampler #(
    parameter int prescale_width = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_in,
    input  logic [prescale_width-1:0] prescale,
    input  logic                      counting,
    input  logic                      start_det,
    output logic                      rx_s,
    output logic                      sampled_bit,
    output logic                      bit_end
);

    logic                      sync1;
    logic [prescale_width-1:0] cnt;
    logic [prescale_width-1:0] half;
    logic                      s0, s1, s2;

    assign half    = prescale >> 1;
    assign bit_end = counting && (cnt == prescale - prescale_width'(1));

    // The start-detection cycle counts as edge 0, so the counter enters START at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b1;
            rx_s        <= 1'b1;
            cnt         <= '0;
            s0          <= 1'b0;
            s1          <= 1'b0;
            s2          <= 1'b0;
            sampled_bit <= 1'b0;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;

            if (!counting)
                cnt <= start_det ? prescale_width'(1) : '0;
            else if (cnt == prescale - prescale_width'(1))
                cnt <= '0;
            else
                cnt <= cnt + prescale_width'(1);

            if (cnt == half - prescale_width'(2)) s0 <= rx_s;
            if (cnt == half - prescale_width'(1)) s1 <= rx_s;
            if (cnt == half)                      s2 <= rx_s;
            if (cnt == half + prescale_width'(1))
                sampled_bit <= (s0 & s1) | (s0 & s2) | (s1 & s2);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: frame FSM, data shift register, parity check and
// registered one-cycle result pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int data_width     = 8,
    parameter int prescale_width = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_in,
    input  logic [prescale_width-1:0] prescale,
    input  logic                      par_en,
    input  logic                      par_typ,
    output logic [data_width-1:0]     P_data,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stop_err
);

    localparam int BW = $clog2(data_width + 1);

    rx_state_t                 state;
    logic [BW-1:0]             bit_cnt;
    logic [data_width-1:0]     shift_reg;
    logic [prescale_width-1:0] p_lat;
    logic                      par_en_lat;
    logic                      par_typ_lat;
    logic                      par_bad;
    logic                      frame_done;
    logic                      stop_ok;

    logic rx_s;
    logic sampled_bit;
    logic bit_end;
    logic counting;
    logic start_det;

    assign counting  = (state != IDLE);
    assign start_det = (state == IDLE) && !rx_s;

    uart_rx_bit_sampler #(
        .prescale_width(prescale_width)
    ) bit_sampler (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .prescale   (p_lat),
        .counting   (counting),
        .start_det  (start_det),
        .rx_s       (rx_s),
        .sampled_bit(sampled_bit),
        .bit_end    (bit_end)
    );

    // Results are issued one cycle after the stop bit ends, which may overlap
    // the detection cycle of a back-to-back frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            p_lat       <= prescale_width'(PRESCALE_8);
            par_en_lat  <= 1'b0;
            par_typ_lat <= PAR_EVEN;
            par_bad     <= 1'b0;
            frame_done  <= 1'b0;
            stop_ok     <= 1'b0;
            P_data      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stop_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
            frame_done <= 1'b0;

            if (frame_done) begin
                if (par_bad)
                    par_err <= 1'b1;
                else if (!stop_ok)
                    stop_err <= 1'b1;
                else begin
                    data_valid <= 1'b1;
                    P_data     <= shift_reg;
                end
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state       <= START;
                        p_lat       <= prescale_width'(legal_prescale(8'(prescale)));
                        par_en_lat  <= par_en;
                        par_typ_lat <= par_typ;
                        par_bad     <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= sampled_bit ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= {sampled_bit, shift_reg[data_width-1:1]};
                        if (bit_cnt == BW'(data_width - 1)) begin
                            bit_cnt <= '0;
                            state   <= par_en_lat ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        par_bad <= (sampled_bit != ((^shift_reg) ^ par_typ_lat));
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        frame_done <= 1'b1;
                        stop_ok    <= sampled_bit;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
